fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the PC register, selects the next PC (exception redirect, decode-stage branch, or sequential), drives the SRAM-like instruction bus with at most one outstanding request, and buffers the returned word until decode accepts it. It consumes `stallF` from the hazard unit and returns `fetch_busy`, which the hazard unit uses to stall decode while no valid instruction is available.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_npc.sv | 57 +++++
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // Fetch-to-decode register payload
  typedef struct packed {
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcF;
    logic            adel;
  } fetch_out_t;

endpackage

// File: rtl/fetch_npc.sv
// Next-PC select with pending redirect/branch registers.
// A live redirect/branch this cycle is honoured directly, so a pulse that
// coincides with a PC update is never lost.
module fetch_npc
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] pc,
  input  logic            advance,
  output logic [XLEN-1:0] nextPc_c
);

  logic            pendRedirValid;
  logic [XLEN-1:0] pendRedirPc;
  logic            pendBranchValid;
  logic [XLEN-1:0] pendBranchPc;

  // Priority: redirect (live, then pending) > branch (live, then pending) > pc+4
  always_comb begin
    nextPc_c = pc + XLEN'(4);
    if (redirect_valid) begin
      nextPc_c = redirect_pc;
    end else if (pendRedirValid) begin
      nextPc_c = pendRedirPc;
    end else if (branch_taken) begin
      nextPc_c = branch_target;
    end else if (pendBranchValid) begin
      nextPc_c = pendBranchPc;
    end
  end

  // Pending registers: cleared when the PC moves, a redirect overrides a branch
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pendRedirValid  <= 1'b0;
      pendRedirPc     <= '0;
      pendBranchValid <= 1'b0;
      pendBranchPc    <= '0;
    end else if (advance) begin
      pendRedirValid  <= 1'b0;
      pendBranchValid <= 1'b0;
    end else if (redirect_valid) begin
      pendRedirValid  <= 1'b1;
      pendRedirPc     <= redirect_pc;
      pendBranchValid <= 1'b0;
    end else if (branch_taken) begin
      pendBranchValid <= 1'b1;
      pendBranchPc    <= branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding instruction bus
// master and the fetch/decode output register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            stallF,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            ireq_ready,
  input  logic            iresp_valid,
  input  logic [XLEN-1:0] iresp_data,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pcF,
  output logic            adel,
  output logic            fetch_busy
);

  fetch_state_t    state, stateNext;
  logic [XLEN-1:0] pc, pcNext, nextPc_c;
  fetch_out_t      outQ, outNext;
  logic            discard, discardNext;
  logic            ireqValidQ, ireqValidNext;
  logic            busyQ, busyNext;
  logic            advance_c, handshake_c, misaligned_c;

  assign handshake_c  = ireqValidQ & ireq_ready;
  assign misaligned_c = (pc[1:0] != 2'b00);

  fetch_npc uNpc (
    .clk           (clk),
    .resetn        (resetn),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .advance       (advance_c),
    .nextPc_c      (nextPc_c)
  );

  // Next state, next PC and next output register contents
  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    outNext     = outQ;
    discardNext = discard;
    advance_c   = 1'b0;

    unique case (state)
      REQ: begin
        if (redirect_valid && !handshake_c) begin
          // No address accepted yet, so the request can simply retarget
          advance_c = 1'b1;
        end else if (handshake_c) begin
          stateNext   = WAIT;
          discardNext = redirect_valid;
        end else if (misaligned_c) begin
          stateNext           = HOLD;
          outNext.instr_valid = 1'b1;
          outNext.instr       = '0;
          outNext.pcF         = pc;
          outNext.adel        = 1'b1;
        end
      end
      WAIT: begin
        if (iresp_valid) begin
          if (discard || redirect_valid) begin
            advance_c   = 1'b1;
            stateNext   = REQ;
            discardNext = 1'b0;
          end else begin
            stateNext           = HOLD;
            outNext.instr_valid = 1'b1;
            outNext.instr       = iresp_data;
            outNext.pcF         = pc;
            outNext.adel        = 1'b0;
          end
        end else if (redirect_valid) begin
          discardNext = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid || !stallF) begin
          advance_c           = 1'b1;
          stateNext           = REQ;
          outNext.instr_valid = 1'b0;
        end
      end
      default: begin
        stateNext = REQ;
      end
    endcase

    if (advance_c) begin
      pcNext = nextPc_c;
    end
    if (redirect_valid) begin
      outNext.instr_valid = 1'b0;
    end
    ireqValidNext = (stateNext == REQ) && (pcNext[1:0] == 2'b00);
    busyNext      = !outNext.instr_valid;
  end

  // State, PC and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= REQ;
      pc         <= RESET_PC;
      outQ       <= '0;
      discard    <= 1'b0;
      ireqValidQ <= 1'b0;
      busyQ      <= 1'b1;
    end else begin
      state      <= stateNext;
      pc         <= pcNext;
      outQ       <= outNext;
      discard    <= discardNext;
      ireqValidQ <= ireqValidNext;
      busyQ      <= busyNext;
    end
  end

  assign ireq_valid  = ireqValidQ;
  assign ireq_addr   = pc;
  assign instr_valid = outQ.instr_valid;
  assign instr       = outQ.instr;
  assign pcF         = outQ.pcF;
  assign adel        = outQ.adel;
  assign fetch_busy  = busyQ;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit with a program-order model:
// it tracks which PC decode must see next and checks every consumed word.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk;
  logic        resetn;
  logic        stallF;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pcF;
  logic        adel;
  logic        fetch_busy;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .stallF        (stallF),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .ireq_ready    (ireq_ready),
    .iresp_valid   (iresp_valid),
    .iresp_data    (iresp_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .pcF           (pcF),
    .adel          (adel),
    .fetch_busy    (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // memory responder state
  logic        memBusy;
  logic [31:0] memAddr;
  int          memCount;
  int          memLatency;
  logic        memOverride;
  logic [31:0] memOverrideData;
  logic        strayResp;

  // program-order model state
  logic [31:0] expPc;
  logic        pendValid;
  logic [31:0] pendTarget;
  logic        prevHeld;
  logic        prevRedir;
  logic [31:0] heldInstr;
  logic [31:0] heldPc;
  logic        heldAdel;
  logic        lastConsume;
  int          consumes;
  int          idle;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] randTarget();
    logic [31:0] t;
    t = RST_PC | (32'($urandom_range(4095)) << 2);
    if ($urandom_range(7) == 0) t = t | 32'($urandom_range(3, 1));
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: answer the bus, check outputs, update the model, advance to next negedge
  task automatic step();
    logic consume;
    logic [31:0] expInstr;
    chk("busy_eq_not_valid", 32'(fetch_busy), 32'(!instr_valid));
    if (prevHeld) begin
      chk("hold_instr", instr, heldInstr);
      chk("hold_pcF", pcF, heldPc);
      chk("hold_adel", 32'(adel), 32'(heldAdel));
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_noreq", 32'(ireq_valid), 32'd0);
    end
    if (prevRedir) chk("redirect_flush", 32'(instr_valid), 32'd0);

    iresp_valid = 1'b0;
    iresp_data  = 32'h0;
    if (memBusy) begin
      if (memCount == 0) begin
        iresp_valid = 1'b1;
        iresp_data  = memOverride ? memOverrideData : memWord(memAddr);
        memBusy     = 1'b0;
      end else begin
        memCount--;
      end
    end
    if (strayResp) begin
      iresp_valid = 1'b1;
      iresp_data  = 32'hDEAD_BEEF;
    end
    if (ireq_valid) begin
      chk("one_outstanding", 32'(memBusy), 32'd0);
      if (ireq_ready) begin
        if (!redirect_valid) chk("req_addr", ireq_addr, expPc);
        memBusy  = 1'b1;
        memAddr  = ireq_addr;
        memCount = memLatency - 1;
      end
    end

    consume = instr_valid && !stallF && !redirect_valid;
    if (consume) begin
      expInstr = (expPc[1:0] != 2'b00) ? 32'h0 : memWord(expPc);
      chk("consume_pcF", pcF, expPc);
      chk("consume_instr", instr, expInstr);
      chk("consume_adel", 32'(adel), 32'(expPc[1:0] != 2'b00));
      consumes++;
      idle = 0;
    end else begin
      idle++;
    end
    prevHeld  = instr_valid && stallF && !redirect_valid;
    heldInstr = instr;
    heldPc    = pcF;
    heldAdel  = adel;
    prevRedir = redirect_valid;

    if (redirect_valid) begin
      expPc     = redirect_pc;
      pendValid = 1'b0;
    end else begin
      if (branch_taken) begin
        pendValid  = 1'b1;
        pendTarget = branch_target;
      end
      if (consume) begin
        expPc     = pendValid ? pendTarget : expPc + 32'd4;
        pendValid = 1'b0;
      end
    end
    lastConsume = consume;

    @(negedge clk);
    redirect_valid = 1'b0;
    branch_taken   = 1'b0;
  endtask

  task automatic resetModel();
    memBusy     = 1'b0;
    expPc       = RST_PC;
    pendValid   = 1'b0;
    prevHeld    = 1'b0;
    prevRedir   = 1'b0;
    lastConsume = 1'b0;
    idle        = 0;
  endtask

  task automatic waitValid(input string tag);
    for (int n = 0; n < 20 && !instr_valid; n++) step();
    chk(tag, 32'(instr_valid), 32'd1);
  endtask

  task automatic waitReq(input string tag, input logic [31:0] addr);
    for (int n = 0; n < 20 && !ireq_valid; n++) step();
    chk({tag, "_valid"}, 32'(ireq_valid), 32'd1);
    chk({tag, "_addr"}, ireq_addr, addr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; stallF = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    branch_taken = 1'b0; branch_target = 32'h0; ireq_ready = 1'b0;
    iresp_valid = 1'b0; iresp_data = 32'h0;
    memOverride = 1'b0; memOverrideData = 32'h0; strayResp = 1'b0;
    memLatency = 1; memAddr = 32'h0; memCount = 0; consumes = 0;
    heldInstr = 32'h0; heldPc = 32'h0; heldAdel = 1'b0; pendTarget = 32'h0;
    resetModel();

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_ireq_valid", 32'(ireq_valid), 32'd0);
    chk("rst_ireq_addr", ireq_addr, RST_PC);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pcF", pcF, 32'h0);
    chk("rst_adel", 32'(adel), 32'd0);
    chk("rst_busy", 32'(fetch_busy), 32'd1);
    resetn = 1'b1;

    // sequential fetch, ready=1, k=1
    ireq_ready = 1'b1;
    step();
    chk("first_req_valid", 32'(ireq_valid), 32'd1);
    chk("first_req_addr", ireq_addr, RST_PC);
    step();
    chk("wait_no_req", 32'(ireq_valid), 32'd0);
    step();
    chk("lat_valid", 32'(instr_valid), 32'd1);
    chk("lat_pcF", pcF, RST_PC);
    chk("lat_instr", instr, memWord(RST_PC));
    step();
    chk("seq_req_valid", 32'(ireq_valid), 32'd1);
    chk("seq_req_addr", ireq_addr, 32'hBFC0_0004);

    // hold under stall
    waitValid("hold_fill");
    stallF = 1'b1;
    repeat (5) step();
    chk("hold_end_valid", 32'(instr_valid), 32'd1);
    chk("hold_end_pcF", pcF, 32'hBFC0_0004);
    chk("hold_end_noreq", 32'(ireq_valid), 32'd0);
    stallF = 1'b0;
    step();
    waitReq("after_hold_req", 32'hBFC0_0008);

    // branch during WAIT
    memLatency = 2;
    step();
    branch_taken = 1'b1; branch_target = 32'hBFC0_0100;
    step();
    waitValid("br_fill");
    chk("br_slot_pcF", pcF, 32'hBFC0_0008);
    step();
    waitReq("br_req", 32'hBFC0_0100);

    // redirect during WAIT drops the returning word
    memLatency = 3; memOverride = 1'b1; memOverrideData = 32'hDEAD_BEEF;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0380;
    step();
    ireq_ready = 1'b0;
    repeat (6) begin
      chk("redir_dropped", 32'(instr_valid), 32'd0);
      step();
    end
    chk("redir_req_valid", 32'(ireq_valid), 32'd1);
    chk("redir_req_addr", ireq_addr, 32'hBFC0_0380);
    memOverride = 1'b0; memLatency = 1; ireq_ready = 1'b1;
    waitValid("redir_fill");
    step();

    // branch to a misaligned target
    branch_taken = 1'b1; branch_target = 32'hBFC0_0102;
    step();
    waitValid("mis_slot_fill");
    step();
    chk("mis_noreq", 32'(ireq_valid), 32'd0);
    step();
    chk("mis_valid", 32'(instr_valid), 32'd1);
    chk("mis_adel", 32'(adel), 32'd1);
    chk("mis_instr", instr, 32'h0);
    chk("mis_pcF", pcF, 32'hBFC0_0102);
    stallF = 1'b1;
    repeat (2) step();
    redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0200; stallF = 1'b0;
    step();
    chk("redir_hold_req", ireq_addr, 32'hBFC0_0200);

    // async reset in the middle of WAIT
    memLatency = 3;
    step();
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_addr", ireq_addr, RST_PC);
    chk("async_rst_valid", 32'(ireq_valid), 32'd0);
    chk("async_rst_busy", 32'(fetch_busy), 32'd1);
    resetModel();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    strayResp = 1'b1; ireq_ready = 1'b0;
    step();
    step();
    strayResp = 1'b0;
    chk("stray_ignored", 32'(instr_valid), 32'd0);
    chk("post_rst_req_valid", 32'(ireq_valid), 32'd1);
    chk("post_rst_req_addr", ireq_addr, RST_PC);
    ireq_ready = 1'b1; memLatency = 1;
    waitValid("post_rst_fill");
    chk("post_rst_pcF", pcF, RST_PC);

    // randomized traffic against the program-order model
    consumes = 0;
    for (int c = 0; c < 4000; c++) begin
      stallF     = ($urandom_range(2) == 0);
      ireq_ready = ($urandom_range(1) == 1);
      memLatency = int'($urandom_range(3, 1));
      if ($urandom_range(39) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = randTarget();
      end
      if (lastConsume && $urandom_range(1) == 0) begin
        branch_taken  = 1'b1;
        branch_target = randTarget();
      end
      step();
      if (idle > 200) begin
        chk("progress_idle", 32'(idle), 32'd0);
        break;
      end
    end
    chk("random_consumes", 32'(consumes >= 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
